// File: rtl/seq_alu.sv
// seq_alu: registered W-bit ALU with a valid/ready handshake, a persistent
// carry register for multi-word arithmetic, optional signed saturation, and
// iterative unsigned multiply / restoring divide.
module seq_alu #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         cin_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic [W-1:0] rslt_hi,
    output logic         carry_out,
    output logic         ovf,
    output logic         branch_flag,
    output logic         div0
);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_XOR  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_SHL  = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SADD = 5'b00101;
    localparam logic [4:0] OP_SSUB = 5'b00110;
    localparam logic [4:0] OP_LTU  = 5'b00111;
    localparam logic [4:0] OP_GTU  = 5'b01000;
    localparam logic [4:0] OP_EQ   = 5'b01001;
    localparam logic [4:0] OP_SUBU = 5'b01010;
    localparam logic [4:0] OP_LTS  = 5'b01011;
    localparam logic [4:0] OP_GTS  = 5'b01100;
    localparam logic [4:0] OP_ADDU = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIVU = 5'b01111;

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, BUSY} state_t;

    // One completed result as it lands in the output registers.
    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c;
        logic         v;
        logic         br;
        logic         dz;
    } res_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic          is_mul_q;
    logic [W-1:0]  b_q, hi_q, lo_q;

    logic          cin, accept, needs_iter, sets_carry;
    logic          load_sc, start, finish;
    res_t          sc;
    logic [W:0]    add_w, sub_w;
    logic [W-1:0]  sadd, ssub;
    logic          sadd_v, ssub_v;
    logic [W:0]    mul_sum, div_shift, div_trial;
    logic [W-1:0]  hi_n, lo_n;

    assign in_ready   = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign cin        = cin_sel & carry_q;
    assign needs_iter = (alu_op == OP_MUL) || ((alu_op == OP_DIVU) && (in_b != '0));
    assign sets_carry = (alu_op == OP_SHL) || (alu_op == OP_SHR) ||
                        (alu_op == OP_SUBU) || (alu_op == OP_ADDU);

    assign add_w  = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, cin};
    assign sub_w  = {1'b0, in_a} - {1'b0, in_b} - {{W{1'b0}}, cin};
    assign sadd   = in_a + in_b;
    assign ssub   = in_a - in_b;
    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign sadd_v = (in_a[W-1] == in_b[W-1]) && (sadd[W-1] != in_a[W-1]);
    assign ssub_v = (in_a[W-1] != in_b[W-1]) && (ssub[W-1] != in_a[W-1]);

    // Single-cycle result, computed straight from the request operands.
    always_comb begin
        sc    = '0;
        sc.lo = in_a;
        case (alu_op)
            OP_AND:  sc.lo = in_a & in_b;
            OP_XOR:  sc.lo = in_a ^ in_b;
            OP_OR:   sc.lo = in_a | in_b;
            OP_SHL: begin
                sc.lo = {in_a[W-2:0], cin};
                sc.c  = in_a[W-1];
            end
            OP_SHR: begin
                sc.lo = {1'b0, in_a[W-1:1]};
                sc.c  = in_a[0];
            end
            OP_SADD: begin
                sc.v  = sadd_v;
                sc.c  = sadd_v;
                sc.lo = (SAT && sadd_v) ? (in_a[W-1] ? SAT_MIN : SAT_MAX) : sadd;
            end
            OP_SSUB: begin
                sc.v  = ssub_v;
                sc.c  = ssub_v;
                sc.lo = (SAT && ssub_v) ? (in_a[W-1] ? SAT_MIN : SAT_MAX) : ssub;
            end
            OP_LTU: begin
                sc.lo = '0;
                sc.br = in_a < in_b;
            end
            OP_GTU: begin
                sc.lo = '0;
                sc.br = in_a > in_b;
            end
            OP_EQ: begin
                sc.lo = '0;
                sc.br = in_a == in_b;
            end
            OP_LTS: begin
                sc.lo = '0;
                sc.br = $signed(in_a) < $signed(in_b);
            end
            OP_GTS: begin
                sc.lo = '0;
                sc.br = $signed(in_a) > $signed(in_b);
            end
            OP_SUBU: begin
                sc.lo = sub_w[W-1:0];
                sc.c  = sub_w[W];
            end
            OP_ADDU: begin
                sc.lo = add_w[W-1:0];
                sc.c  = add_w[W];
            end
            // Only the divide-by-zero case of DIVU takes the single-cycle path.
            OP_DIVU: begin
                sc.lo = '1;
                sc.hi = in_a;
                sc.dz = 1'b1;
            end
            default: sc.lo = in_a;
        endcase
    end

    // One shift-add or restoring-divide step on the {hi_q, lo_q} pair.
    always_comb begin
        hi_n      = hi_q;
        lo_n      = lo_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (is_mul_q) begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end else if (!div_trial[W]) begin
            hi_n = div_trial[W-1:0];
            lo_n = {lo_q[W-2:0], 1'b1};
        end else begin
            hi_n = div_shift[W-1:0];
            lo_n = {lo_q[W-2:0], 1'b0};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and the load/start/finish strobes.
    always_comb begin
        state_d = state_q;
        load_sc = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (needs_iter) begin
                        start   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        load_sc = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration datapath: latch operands at start, step once per BUSY cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (start) begin
            cnt_q    <= '0;
            is_mul_q <= (alu_op == OP_MUL);
            b_q      <= in_b;
            hi_q     <= '0;
            lo_q     <= in_a;
        end else if (state_q == BUSY) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= finish ? '0 : cnt_q + 1'b1;
        end
    end

    // Carry register: written only when a carry-producing op completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    carry_q <= 1'b0;
        else if (load_sc && sets_carry) carry_q <= sc.c;
    end

    // Output slot: load on completion, hold under backpressure, drop on take.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            rslt        <= '0;
            rslt_hi     <= '0;
            carry_out   <= 1'b0;
            ovf         <= 1'b0;
            branch_flag <= 1'b0;
            div0        <= 1'b0;
        end else if (load_sc) begin
            out_valid   <= 1'b1;
            rslt        <= sc.lo;
            rslt_hi     <= sc.hi;
            carry_out   <= sc.c;
            ovf         <= sc.v;
            branch_flag <= sc.br;
            div0        <= sc.dz;
        end else if (finish) begin
            out_valid   <= 1'b1;
            rslt        <= lo_n;
            rslt_hi     <= hi_n;
            carry_out   <= 1'b0;
            ovf         <= 1'b0;
            branch_flag <= 1'b0;
            div0        <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a saturating and a wrapping instance share
// the same stimulus; expectations come from an integer-arithmetic model.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk, reset;
    logic         in_valid, cin_sel, out_ready;
    logic [4:0]   alu_op;
    logic [W-1:0] in_a, in_b;

    logic         in_ready, out_valid, carry_out, ovf, branch_flag, div0;
    logic [W-1:0] rslt, rslt_hi;
    logic         in_ready_w, out_valid_w, carry_out_w, ovf_w, branch_flag_w, div0_w;
    logic [W-1:0] rslt_w, rslt_hi_w;

    seq_alu #(.W(W), .SAT(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .in_a(in_a), .in_b(in_b), .cin_sel(cin_sel),
        .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt),
        .rslt_hi(rslt_hi), .carry_out(carry_out), .ovf(ovf),
        .branch_flag(branch_flag), .div0(div0)
    );

    seq_alu #(.W(W), .SAT(1'b0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .alu_op(alu_op), .in_a(in_a), .in_b(in_b), .cin_sel(cin_sel),
        .out_valid(out_valid_w), .out_ready(out_ready), .rslt(rslt_w),
        .rslt_hi(rslt_hi_w), .carry_out(carry_out_w), .ovf(ovf_w),
        .branch_flag(branch_flag_w), .div0(div0_w)
    );

    // Expected results for both instances: {div0, br, ovf, carry, hi, lo}.
    typedef struct packed {
        logic [19:0] e_sat;
        logic [19:0] e_wrap;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   carry_ref = 1'b0;
    bit   rand_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic logic [19:0] model(input int op, input int a, input int b,
                                          input int cin, input bit sat);
        int r, hi, c, o, br, dz, sa, sb, s;
        r = a; hi = 0; c = 0; o = 0; br = 0; dz = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0:  r = a & b;
            1:  r = a ^ b;
            2:  r = a | b;
            3:  begin r = (a * 2 + cin) % 256; c = a / 128; end
            4:  begin r = a / 2; c = a % 2; end
            5, 6: begin
                s = (op == 5) ? sa + sb : sa - sb;
                o = (s > 127 || s < -128) ? 1 : 0;
                c = o;
                if (o != 0 && sat) r = (s > 127) ? 127 : 128;
                else               r = s & 255;
            end
            7:  begin r = 0; br = (a < b) ? 1 : 0; end
            8:  begin r = 0; br = (a > b) ? 1 : 0; end
            9:  begin r = 0; br = (a == b) ? 1 : 0; end
            11: begin r = 0; br = (sa < sb) ? 1 : 0; end
            12: begin r = 0; br = (sa > sb) ? 1 : 0; end
            10: begin s = a - b - cin; c = (s < 0) ? 1 : 0; r = s & 255; end
            13: begin s = a + b + cin; c = (s > 255) ? 1 : 0; r = s & 255; end
            14: begin s = a * b; r = s & 255; hi = (s >> 8) & 255; end
            15: begin
                if (b == 0) begin r = 255; hi = a; dz = 1; end
                else        begin r = a / b; hi = a % b; end
            end
            default: r = a;
        endcase
        return {dz[0], br[0], o[0], c[0], hi[7:0], r[7:0]};
    endfunction

    // Present one request, wait (bounded) for acceptance, queue its expectation.
    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cs, output logic [19:0] exp_sat);
        int   t;
        int   cin;
        exp_t e;
        t = 0;
        in_valid = 1'b1; alu_op = op; in_a = a; in_b = b; cin_sel = cs;
        #1;
        while (!in_ready && t < 100) begin
            @(posedge clk); #3;
            t++;
        end
        exp_sat = '0;
        if (!in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            cin      = cs ? int'(carry_ref) : 0;
            e.e_sat  = model(int'(op), int'(a), int'(b), cin, 1'b1);
            e.e_wrap = model(int'(op), int'(a), int'(b), cin, 1'b0);
            if (op inside {5'd3, 5'd4, 5'd10, 5'd13}) carry_ref = e.e_sat[16];
            sbq.push_back(e);
            exp_sat = e.e_sat;
            #2;
            in_valid = 1'b0;
        end
    endtask

    // Random consumer backpressure, changed just after each edge.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = (($urandom % 4) != 0);
    end

    // Monitor: compare each result as the consumer takes it.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL spurious_result: got rslt %h, required no result", rslt);
            end else begin
                mon_e = sbq.pop_front();
                check("result_sat",
                      32'({div0, branch_flag, ovf, carry_out, rslt_hi, rslt}),
                      32'(mon_e.e_sat));
                check("result_wrap",
                      32'({out_valid_w, div0_w, branch_flag_w, ovf_w, carry_out_w, rslt_hi_w, rslt_w}),
                      32'({1'b1, mon_e.e_wrap}));
            end
        end
    end

    initial begin
        logic [19:0] ex;
        logic [4:0]  rop;
        logic [7:0]  ra, rb;
        int          cnt;

        reset = 1'b1; in_valid = 1'b0; alu_op = '0; in_a = '0; in_b = '0;
        cin_sel = 1'b0; out_ready = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_outputs", 32'({out_valid, carry_out, ovf, branch_flag, div0, rslt_hi, rslt}), 32'd0);
        check("rst_outputs_w", 32'({out_valid_w, carry_out_w, ovf_w, branch_flag_w, div0_w, rslt_hi_w, rslt_w}), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Multi-word carry chain.
        issue(5'd13, 8'hF0, 8'h20, 1'b0, ex);
        check("chain_lo", 32'({carry_out, rslt}), 32'h110);
        issue(5'd13, 8'h00, 8'h00, 1'b1, ex);
        check("chain_hi", 32'({carry_out, rslt}), 32'h001);

        // Saturating vs wrapping signed add/sub.
        issue(5'd5, 8'h70, 8'h20, 1'b0, ex);
        check("sadd_sat", 32'({ovf, rslt}), 32'h17F);
        check("sadd_wrap", 32'({ovf_w, rslt_w}), 32'h190);
        issue(5'd6, 8'h80, 8'h01, 1'b0, ex);
        check("ssub_sat", 32'({ovf, rslt}), 32'h180);

        // MUL latency, with a live carry that must survive it.
        issue(5'd13, 8'hFF, 8'h01, 1'b0, ex);
        issue(5'd14, 8'hFF, 8'hFF, 1'b0, ex);
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #2;
            cnt++;
        end
        check("mul_busy_cycles", 32'(cnt), 32'd8);
        check("mul_result", 32'({out_valid, rslt_hi, rslt}), 32'h1FE01);
        issue(5'd13, 8'h00, 8'h00, 1'b1, ex);
        check("carry_after_mul", 32'({carry_out, rslt}), 32'h001);

        // Division, including divide by zero completing in one cycle.
        issue(5'd15, 8'd200, 8'd7, 1'b0, ex);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #2;
            cnt++;
        end
        check("divu", 32'({div0, rslt_hi, rslt}), 32'h0041C);
        issue(5'd15, 8'h55, 8'h00, 1'b0, ex);
        check("div0_1cycle", 32'({out_valid, div0, rslt_hi, rslt}), 32'h355FF);

        // Backpressure: hold the slot, then take and load on the same edge.
        @(posedge clk); #2;
        out_ready = 1'b0;
        issue(5'd0, 8'h3C, 8'hA5, 1'b0, ex);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({out_valid, in_ready, rslt}), 32'h224);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        issue(5'd1, 8'h3C, 8'hA5, 1'b0, ex);
        check("bp_take_load", 32'({out_valid, rslt}), 32'h199);

        // Reset in the middle of a multiply.
        issue(5'd13, 8'hFF, 8'h01, 1'b0, ex);
        issue(5'd14, 8'h12, 8'h34, 1'b0, ex);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_mul", 32'({out_valid, in_ready}), 32'h1);
        sbq.delete();
        carry_ref = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rst_mid_idle", 32'({out_valid, in_ready}), 32'h1);
        issue(5'd13, 8'h01, 8'h01, 1'b1, ex);
        check("carry_cleared", 32'({carry_out, rslt}), 32'h002);

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rop = 5'($urandom_range(0, 20));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(rop, ra, rb, 1'($urandom), ex);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #2;
            end
        end

        // Drain outstanding results.
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        cnt = 0;
        while (sbq.size() != 0 && cnt < 50) begin
            @(posedge clk); #2;
            cnt++;
        end
        check("drain", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
